// File: rtl/rfid_pcd_pkg.sv
// Shared types and CRC_A constants for the ISO 14443-A PCD transmit framer.
package rfid_pcd_pkg;

    typedef enum logic [1:0] {
        SHORT        = 2'd0,
        STANDARD     = 2'd1,
        BIT_ORIENTED = 2'd2
    } frame_mode_t;

    typedef enum logic [1:0] {
        SYM_X = 2'd0,
        SYM_Y = 2'd1,
        SYM_Z = 2'd2
    } miller_sym_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SOC    = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_CRC    = 3'd4,
        ST_EOC0   = 3'd5,
        ST_EOCY   = 3'd6
    } framer_state_t;

    localparam logic [15:0] CRC_A_INIT = 16'h6363;
    localparam logic [15:0] CRC_A_POLY = 16'h8408;

    function automatic logic [15:0] crc_a_step(input logic [15:0] crc, input logic b);
        logic [15:0] shifted;
        shifted = {1'b0, crc[15:1]};
        return (crc[0] ^ b) ? (shifted ^ CRC_A_POLY) : shifted;
    endfunction

endpackage

// File: rtl/pcd_miller_framer_if.sv
// Request/status bundle between the reader command FSM and the Miller framer.
interface pcd_miller_framer_if #(
    parameter int MAX_BYTES = 16
);
    localparam int NBW = $clog2(MAX_BYTES + 1);

    logic [8*MAX_BYTES-1:0] data_in;
    logic [NBW-1:0]         num_bytes_in;
    logic [2:0]             last_bits_in;
    logic [1:0]             mode_in;
    logic                   crc_en_in;
    logic                   trigger_in;
    logic                   busy_out;
    logic                   done_out;
    logic                   err_out;
    logic                   amp_out;

    modport master (
        output data_in, num_bytes_in, last_bits_in, mode_in, crc_en_in, trigger_in,
        input  busy_out, done_out, err_out, amp_out
    );

    modport slave (
        input  data_in, num_bytes_in, last_bits_in, mode_in, crc_en_in, trigger_in,
        output busy_out, done_out, err_out, amp_out
    );
endinterface

// File: rtl/pcd_miller_framer_symbol_gen.sv
// Plays one modified-Miller symbol per TICKS_PER_BIT ticks; next symbol loads on sym_done.
module miller_symbol_gen
    import rfid_pcd_pkg::*;
#(
    parameter int TICKS_PER_BIT = 4,
    parameter int PAUSE_TICKS   = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sym_valid,
    input  miller_sym_t sym,
    output logic        sym_done,
    output logic        amp
);
    localparam int TW = (TICKS_PER_BIT > 2) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int HALF = TICKS_PER_BIT / 2;

    logic          active;
    miller_sym_t   cur_sym;
    logic [TW-1:0] cnt;
    logic          pause;
    int            c;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            active  <= 1'b0;
            cur_sym <= SYM_Y;
            cnt     <= '0;
        end else if (sym_valid) begin
            active  <= 1'b1;
            cur_sym <= sym;
            cnt     <= TW'(TICKS_PER_BIT - 1);
        end else if (sym_done) begin
            active <= 1'b0;
        end else if (active) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign sym_done = active && (cnt == '0);

    // cnt counts down, so tick index t = TICKS_PER_BIT-1-cnt
    always_comb begin
        c     = int'(cnt);
        pause = 1'b0;
        case (cur_sym)
            SYM_X:   pause = (c >= HALF - PAUSE_TICKS) && (c <= HALF - 1);
            SYM_Z:   pause = (c >= TICKS_PER_BIT - PAUSE_TICKS);
            default: pause = 1'b0;
        endcase
        amp = !(active && pause);
    end

endmodule

// File: rtl/pcd_miller_framer.sv
// ISO 14443-A PCD transmit framer: serialises a latched request as modified-Miller ticks.
// state     | meaning
// ST_IDLE   | carrier on, waiting for trigger
// ST_SOC    | start-of-communication Z symbol
// ST_DATA   | payload bit (LSB first)
// ST_PARITY | odd parity after a full byte (payload or CRC)
// ST_CRC    | CRC_A bit, low byte first
// ST_EOC0   | end-of-communication logic 0
// ST_EOCY   | trailing Y symbol
module pcd_miller_framer
    import rfid_pcd_pkg::*;
#(
    parameter int MAX_BYTES     = 16,
    parameter int TICKS_PER_BIT = 4,
    parameter int PAUSE_TICKS   = 1
) (
    input logic                 clk_in,
    input logic                 rst_in,
    pcd_miller_framer_if.slave  bus
);
    localparam int NBW = $clog2(MAX_BYTES + 1);

    framer_state_t          state, state_nx;
    logic [8*MAX_BYTES-1:0] data_q, data_sh;
    logic [NBW-1:0]         n_q, byte_idx, byte_nx;
    logic [2:0]             lb_q, bit_idx, bit_nx;
    frame_mode_t            mode_q;
    logic                   crc_en_q, par_q, prev_q, done_q, err_q;
    logic [15:0]            crc_q;
    logic                   push, tx_bit, soc_push, eocy_push, accept, reject, req_ok, sym_done;
    logic [3:0]             byte_bits;
    miller_sym_t            tx_sym;

    assign req_ok = (bus.mode_in != 2'd3)
                 && (bus.num_bytes_in <= NBW'(MAX_BYTES))
                 && !((bus.num_bytes_in == '0) && (bus.mode_in != 2'd0))
                 && !(bus.crc_en_in && (bus.mode_in != 2'd1));

    always_comb begin
        if (mode_q == SHORT)
            byte_bits = 4'd7;
        else if ((mode_q == BIT_ORIENTED) && (lb_q != 3'd0) && (byte_idx == n_q - NBW'(1)))
            byte_bits = {1'b0, lb_q};
        else
            byte_bits = 4'd8;
    end

    always_comb begin
        state_nx  = state;
        byte_nx   = byte_idx;
        bit_nx    = bit_idx;
        push      = 1'b0;
        tx_bit    = 1'b0;
        soc_push  = 1'b0;
        eocy_push = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            ST_IDLE: if (bus.trigger_in) begin
                if (req_ok) begin
                    accept   = 1'b1;
                    push     = 1'b1;
                    soc_push = 1'b1;
                    state_nx = ST_SOC;
                end else begin
                    reject = 1'b1;
                end
            end
            ST_SOC: if (sym_done) begin
                push     = 1'b1;
                state_nx = ST_DATA;
                byte_nx  = '0;
                bit_nx   = '0;
            end
            ST_DATA: if (sym_done) begin
                push = 1'b1;
                if ({1'b0, bit_idx} + 4'd1 < byte_bits) begin
                    bit_nx = bit_idx + 3'd1;
                end else if (byte_bits != 4'd8) begin
                    state_nx = ST_EOC0;
                end else begin
                    state_nx = ST_PARITY;
                    tx_bit   = par_q;
                end
            end
            ST_PARITY: if (sym_done) begin
                push    = 1'b1;
                byte_nx = byte_idx + NBW'(1);
                bit_nx  = '0;
                // byte_idx runs on past n_q through the two CRC bytes
                if (byte_nx < n_q) begin
                    state_nx = ST_DATA;
                end else if (crc_en_q && ((byte_nx == n_q) || (byte_idx == n_q))) begin
                    state_nx = ST_CRC;
                    tx_bit   = crc_q[0];
                end else begin
                    state_nx = ST_EOC0;
                end
            end
            ST_CRC: if (sym_done) begin
                push = 1'b1;
                if (bit_idx == 3'd7) begin
                    state_nx = ST_PARITY;
                    tx_bit   = par_q;
                end else begin
                    bit_nx = bit_idx + 3'd1;
                    tx_bit = crc_q[0];
                end
            end
            ST_EOC0: if (sym_done) begin
                push      = 1'b1;
                eocy_push = 1'b1;
                state_nx  = ST_EOCY;
            end
            ST_EOCY: if (sym_done) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase

        data_sh = data_q >> {byte_nx, bit_nx};
        if (push && (state_nx == ST_DATA)) tx_bit = data_sh[0];

        if (soc_push)       tx_sym = SYM_Z;
        else if (eocy_push) tx_sym = SYM_Y;
        else if (tx_bit)    tx_sym = SYM_X;
        else                tx_sym = prev_q ? SYM_Y : SYM_Z;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            prev_q   <= 1'b0;
            par_q    <= 1'b0;
            crc_q    <= CRC_A_INIT;
            data_q   <= '0;
            n_q      <= '0;
            lb_q     <= '0;
            mode_q   <= SHORT;
            crc_en_q <= 1'b0;
            byte_idx <= '0;
            bit_idx  <= '0;
        end else begin
            state  <= state_nx;
            done_q <= (state == ST_EOCY) && sym_done;
            err_q  <= reject;
            if (accept) begin
                data_q   <= bus.data_in;
                n_q      <= bus.num_bytes_in;
                lb_q     <= bus.last_bits_in;
                mode_q   <= frame_mode_t'(bus.mode_in);
                crc_en_q <= bus.crc_en_in;
                crc_q    <= CRC_A_INIT;
            end
            if (push) begin
                byte_idx <= byte_nx;
                bit_idx  <= bit_nx;
                prev_q   <= tx_bit;
                if (state_nx == ST_DATA) crc_q <= crc_a_step(crc_q, tx_bit);
                if (state_nx == ST_CRC)  crc_q <= {1'b0, crc_q[15:1]};
                if ((state_nx == ST_DATA) || (state_nx == ST_CRC))
                    par_q <= (bit_nx == 3'd0) ? ~tx_bit : (par_q ^ tx_bit);
            end
        end
    end

    miller_symbol_gen #(
        .TICKS_PER_BIT (TICKS_PER_BIT),
        .PAUSE_TICKS   (PAUSE_TICKS)
    ) u_sym_gen (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .sym_valid (push),
        .sym       (tx_sym),
        .sym_done  (sym_done),
        .amp       (bus.amp_out)
    );

    assign bus.busy_out = (state != ST_IDLE);
    assign bus.done_out = done_q;
    assign bus.err_out  = err_q;

endmodule

// File: tb/tb_pcd_miller_framer.sv
// Scoreboard bench: a list-based Miller reference predicts the amp waveform of every frame.
module tb_pcd_miller_framer;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    pcd_miller_framer_if #(.MAX_BYTES(16)) bus_a ();
    pcd_miller_framer_if #(.MAX_BYTES(16)) bus_b ();

    pcd_miller_framer #(.MAX_BYTES(16), .TICKS_PER_BIT(4), .PAUSE_TICKS(1)) dut_a (
        .clk_in (clk_in), .rst_in (rst_in), .bus (bus_a));
    pcd_miller_framer #(.MAX_BYTES(16), .TICKS_PER_BIT(8), .PAUSE_TICKS(2)) dut_b (
        .clk_in (clk_in), .rst_in (rst_in), .bus (bus_b));

    int checks = 0;
    int errors = 0;
    int exp_done = 0, exp_err = 0, done_seen = 0, err_seen = 0;
    int done_b_seen = 0;
    int busy_cnt = 0, busy_b_cnt = 0;
    logic sb_a[$];
    logic sb_b[$];
    int   len_a[$];
    int   len_b[$];
    logic wave[$];

    function automatic logic [15:0] crc_a(input logic [127:0] d, input int n);
        logic [15:0] crc = 16'h6363;
        for (int b = 0; b < n; b++)
            for (int i = 0; i < 8; i++)
                crc = (crc[0] ^ d[8*b+i]) ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
        return crc;
    endfunction

    // symbols: 0 = X, 1 = Y, 2 = Z
    task automatic gen_wave(input int m, input int n, input int lb, input bit c,
                            input logic [127:0] d, input int tpb, input int p);
        logic bits[$];
        int   syms[$];
        logic prev;
        logic [7:0] by;
        logic [15:0] crc;
        int nfull;
        wave.delete();
        if (m == 0) begin
            for (int i = 0; i < 7; i++) bits.push_back(d[i]);
        end else begin
            nfull = (m == 2 && lb != 0) ? n - 1 : n;
            for (int b = 0; b < nfull; b++) begin
                by = d[8*b +: 8];
                for (int i = 0; i < 8; i++) bits.push_back(by[i]);
                bits.push_back(~^by);
            end
            if (m == 2 && lb != 0)
                for (int i = 0; i < lb; i++) bits.push_back(d[8*(n-1)+i]);
            if (c) begin
                crc = crc_a(d, n);
                for (int k = 0; k < 2; k++) begin
                    by = crc[8*k +: 8];
                    for (int i = 0; i < 8; i++) bits.push_back(by[i]);
                    bits.push_back(~^by);
                end
            end
        end
        syms.push_back(2);
        prev = 1'b0;
        foreach (bits[i]) begin
            syms.push_back(bits[i] ? 0 : (prev ? 1 : 2));
            prev = bits[i];
        end
        syms.push_back(prev ? 1 : 2);
        syms.push_back(1);
        foreach (syms[s])
            for (int t = 0; t < tpb; t++)
                wave.push_back(!((syms[s] == 0 && t >= tpb/2 && t < tpb/2 + p) ||
                                 (syms[s] == 2 && t < p)));
    endtask

    task automatic wait_idle_a();
        int i = 0;
        while (bus_a.busy_out && i < 3000) begin
            @(negedge clk_in);
            i++;
        end
        checks++;
        if (bus_a.busy_out) begin
            errors++;
            $display("FAIL timeout_a busy still %0b after %0d cycles, need 0", bus_a.busy_out, i);
        end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic send(input int m, input int n, input int lb, input bit c,
                        input logic [127:0] d, input int exp_len, input int hold, input bit do_wait);
        bit ok;
        ok = (m != 3) && (n <= 16) && !(n == 0 && m != 0) && !(c && m != 1);
        @(negedge clk_in);
        bus_a.data_in      = d;
        bus_a.num_bytes_in = 5'(n);
        bus_a.last_bits_in = 3'(lb);
        bus_a.mode_in      = 2'(m);
        bus_a.crc_en_in    = c;
        bus_a.trigger_in   = 1'b1;
        if (ok) begin
            gen_wave(m, n, lb, c, d, 4, 1);
            foreach (wave[i]) sb_a.push_back(wave[i]);
            len_a.push_back(exp_len != 0 ? exp_len : wave.size());
            exp_done++;
        end else begin
            exp_err++;
        end
        repeat (hold) @(negedge clk_in);
        bus_a.trigger_in = 1'b0;
        if (!ok) begin
            checks++;
            if (bus_a.err_out !== 1'b1 || bus_a.busy_out !== 1'b0 || bus_a.amp_out !== 1'b1) begin
                errors++;
                $display("FAIL reject m=%0d n=%0d c=%0b got err=%0b busy=%0b amp=%0b, need 1 0 1",
                         m, n, c, bus_a.err_out, bus_a.busy_out, bus_a.amp_out);
            end
            @(negedge clk_in);
            checks++;
            if (bus_a.err_out !== 1'b0 || bus_a.busy_out !== 1'b0) begin
                errors++;
                $display("FAIL reject_pulse got err=%0b busy=%0b, need 0 0", bus_a.err_out, bus_a.busy_out);
            end
        end else if (do_wait) begin
            wait_idle_a();
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (bus_a.busy_out) begin
                busy_cnt++;
                checks++;
                if (sb_a.size() == 0) begin
                    errors++;
                    $display("FAIL amp_a unexpected busy tick at %0t, amp=%0b", $time, bus_a.amp_out);
                end else if (bus_a.amp_out !== sb_a.pop_front()) begin
                    errors++;
                    $display("FAIL amp_a at %0t got %0b, need %0b", $time, bus_a.amp_out, !bus_a.amp_out);
                end
            end else begin
                checks++;
                if (bus_a.amp_out !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_amp_a at %0t got %0b, need 1", $time, bus_a.amp_out);
                end
                if (bus_a.done_out) begin
                    done_seen++;
                    checks++;
                    if (len_a.size() == 0 || busy_cnt != len_a[0]) begin
                        errors++;
                        $display("FAIL busy_len_a got %0d, need %0d", busy_cnt,
                                 len_a.size() ? len_a[0] : -1);
                    end
                    if (len_a.size() != 0) void'(len_a.pop_front());
                    checks++;
                    if (sb_a.size() != 0) begin
                        errors++;
                        $display("FAIL ticks_left_a got %0d, need 0", sb_a.size());
                    end
                end
                busy_cnt = 0;
            end
            if (bus_a.err_out) err_seen++;
        end
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (bus_b.busy_out) begin
                busy_b_cnt++;
                checks++;
                if (sb_b.size() == 0) begin
                    errors++;
                    $display("FAIL amp_b unexpected busy tick at %0t", $time);
                end else if (bus_b.amp_out !== sb_b.pop_front()) begin
                    errors++;
                    $display("FAIL amp_b at %0t got %0b, need %0b", $time, bus_b.amp_out, !bus_b.amp_out);
                end
            end else begin
                if (bus_b.done_out) begin
                    done_b_seen++;
                    checks++;
                    if (len_b.size() == 0 || busy_b_cnt != len_b[0]) begin
                        errors++;
                        $display("FAIL busy_len_b got %0d, need %0d", busy_b_cnt,
                                 len_b.size() ? len_b[0] : -1);
                    end
                    if (len_b.size() != 0) void'(len_b.pop_front());
                end
                busy_b_cnt = 0;
            end
        end
    end

    initial begin
        logic [127:0] rd;
        int m, n, lb, wait_b;
        bit c;
        bus_a.data_in = '0; bus_a.num_bytes_in = '0; bus_a.last_bits_in = '0;
        bus_a.mode_in = '0; bus_a.crc_en_in = 1'b0; bus_a.trigger_in = 1'b0;
        bus_b.data_in = '0; bus_b.num_bytes_in = '0; bus_b.last_bits_in = '0;
        bus_b.mode_in = '0; bus_b.crc_en_in = 1'b0; bus_b.trigger_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (bus_a.busy_out !== 1'b0 || bus_a.done_out !== 1'b0 || bus_a.err_out !== 1'b0 || bus_a.amp_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got busy=%0b done=%0b err=%0b amp=%0b, need 0 0 0 1",
                     bus_a.busy_out, bus_a.done_out, bus_a.err_out, bus_a.amp_out);
        end
        rst_in = 1'b0;

        send(0, 0, 0, 0, 128'h26, 40, 1, 1);
        send(1, 2, 0, 1, 128'h0050, 156, 1, 1);
        send(2, 3, 4, 0, 128'h0A2093, 100, 1, 1);
        send(3, 1, 0, 0, 128'h26, 0, 1, 1);
        send(1, 0, 0, 0, 128'h26, 0, 1, 1);
        send(0, 0, 0, 1, 128'h26, 0, 1, 1);
        send(0, 0, 0, 0, 128'h26, 40, 20, 1);

        send(1, 2, 0, 1, 128'h0050, 156, 1, 0);
        repeat (50) @(negedge clk_in);
        rst_in = 1'b1;
        sb_a.delete();
        void'(len_a.pop_front());
        exp_done--;
        @(negedge clk_in);
        checks++;
        if (bus_a.busy_out !== 1'b0 || bus_a.amp_out !== 1'b1 || bus_a.done_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got busy=%0b amp=%0b done=%0b, need 0 1 0",
                     bus_a.busy_out, bus_a.amp_out, bus_a.done_out);
        end
        rst_in = 1'b0;
        send(1, 2, 0, 1, 128'h0050, 156, 1, 1);

        for (int r = 0; r < 12; r++) begin
            rd = {$urandom(), $urandom(), $urandom(), $urandom()};
            m  = $urandom_range(0, 3);
            n  = ($urandom_range(0, 9) == 0) ? 17 : $urandom_range(0, 4);
            lb = $urandom_range(0, 7);
            c  = (m == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            send(m, n, lb, c, rd, 0, 1, 1);
        end

        @(negedge clk_in);
        bus_b.data_in = 128'h26;
        bus_b.mode_in = 2'd0;
        bus_b.trigger_in = 1'b1;
        gen_wave(0, 0, 0, 0, 128'h26, 8, 2);
        foreach (wave[i]) sb_b.push_back(wave[i]);
        len_b.push_back(80);
        @(negedge clk_in);
        bus_b.trigger_in = 1'b0;
        wait_b = 0;
        while (bus_b.busy_out && wait_b < 500) begin
            @(negedge clk_in);
            wait_b++;
        end
        checks++;
        if (bus_b.busy_out) begin
            errors++;
            $display("FAIL timeout_b busy still 1, need 0");
        end
        repeat (3) @(negedge clk_in);

        checks++;
        if (done_seen != exp_done) begin
            errors++;
            $display("FAIL done_count got %0d, need %0d", done_seen, exp_done);
        end
        checks++;
        if (err_seen != exp_err) begin
            errors++;
            $display("FAIL err_count got %0d, need %0d", err_seen, exp_err);
        end
        checks++;
        if (done_b_seen != 1) begin
            errors++;
            $display("FAIL done_count_b got %0d, need 1", done_b_seen);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
